design187_70_80: RTL and testbench

//  Multi-lane datapath stress block: one WIDTH-bit input word fans out to CHANNEL lanes.

---
 rtl/design187_70_80_pkg.sv | 21 ++
 rtl/design187_70_80_if.sv | 15 +
 rtl/design187_70_80_lane.sv | 47 ++++
 rtl/design187_70_80.sv | 86 ++++++++
 tb/tb_design187_70_80.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/design187_70_80_pkg.sv
// design187_70_80_pkg
//   Shared definitions for the multi-lane mixing datapath.
//   GOLDEN : 32-bit golden-ratio constant used to derive the per-lane constant.
//   k_of() : lane constant K(i) = i * GOLDEN, computed at KMAX_W bits so that
//            callers can truncate it to any datapath width up to KMAX_W.
package design187_70_80_pkg;

   localparam logic [31:0] GOLDEN = 32'h9E37_79B9;
   localparam int          KMAX_W = 128;

   // Lane constant; the constant is zero-extended before the multiply, so the
   // low WIDTH bits are exact for every WIDTH <= KMAX_W.
   function automatic logic [KMAX_W-1:0] k_of(input int unsigned lane);
      logic [KMAX_W-1:0] lane_w;
      logic [KMAX_W-1:0] golden_w;
      lane_w   = KMAX_W'(lane);
      golden_w = KMAX_W'(GOLDEN);
      return lane_w * golden_w;
   endfunction

endpackage

// File: rtl/design187_70_80_if.sv
// design187_70_80_if
//   Data bus of the mixing datapath (no handshake: one word per clock).
//   in  : WIDTH-bit input word, sampled every rising clock edge
//   out : WIDTH-bit registered result word
//   master : the side that produces in and observes out
//   slave  : the datapath itself
interface design187_70_80_if #(
   parameter int WIDTH = 32
);
   logic [WIDTH-1:0] in;
   logic [WIDTH-1:0] out;

   modport master (output in, input out);
   modport slave  (input in, output out);
endinterface

// File: rtl/design187_70_80_lane.sv
// design187_lane
//   One mixing lane: holds the S1 (xor with lane constant) and S2
//   (add self-rotation) registers.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears both registers
//   din  : registered input word shared by all lanes
//   dout : S2 register of this lane
//   LANE : lane index; selects the constant K(LANE) and rotation LANE mod WIDTH
module design187_lane
   import design187_70_80_pkg::*;
#(
   parameter int          WIDTH = 32,
   parameter int unsigned LANE  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   localparam logic [WIDTH-1:0] K_C = WIDTH'(k_of(LANE));
   localparam int unsigned      ROT = LANE % WIDTH;

   logic [WIDTH-1:0]   s1_r;
   logic [WIDTH-1:0]   s2_r;
   logic [2*WIDTH-1:0] dbl_s;
   logic [WIDTH-1:0]   rot_s;

   // A left rotation by ROT is a fixed window into the word concatenated
   // with itself; ROT = 0 selects the upper copy unchanged.
   assign dbl_s = {s1_r, s1_r};
   assign rot_s = dbl_s[2*WIDTH-1-ROT -: WIDTH];

   // S1/S2 lane registers; the add wraps modulo 2^WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_r <= '0;
         s2_r <= '0;
      end else begin
         s1_r <= din ^ K_C;
         s2_r <= s1_r + rot_s;
      end
   end

   assign dout = s2_r;

endmodule

// File: rtl/design187_70_80.sv
// design187_70_80
//   Multi-lane datapath: the input word is registered, fanned out to CHANNEL
//   mixing lanes, and the lane results are XOR-reduced through a balanced
//   tree into a registered output. Latency 4 clocks, one result per clock.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears all state (out = 0 at once)
//   bus : slave modport; bus.in sampled every clock, bus.out registered result
module design187_70_80
   import design187_70_80_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CHANNEL = 70
) (
   input  logic               clk,
   input  logic               rst,
   design187_70_80_if.slave   bus
);

   localparam int LEAVES = 1 << $clog2(CHANNEL);

   logic [WIDTH-1:0]               in_q_r;
   logic [2:0]                     vld_r;
   logic [WIDTH-1:0]               out_r;
   logic [CHANNEL-1:0][WIDTH-1:0]  lane_dout_s;
   logic [WIDTH-1:0]               node_s [2*LEAVES-1];

   // S0 input register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_q_r <= '0;
      end else begin
         in_q_r <= bus.in;
      end
   end

   // Tracks which stages hold a word captured after reset. Without it the
   // cleared S1/S2 registers would still produce lane constants mixed with
   // zero, leaking a non-zero value onto out before the first real result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_r <= 3'b000;
      end else begin
         vld_r <= {vld_r[1:0], 1'b1};
      end
   end

   for (genvar g = 0; g < CHANNEL; g++) begin : g_lane
      design187_lane #(
         .WIDTH (WIDTH),
         .LANE  (g)
      ) u_lane (
         .clk  (clk),
         .rst  (rst),
         .din  (in_q_r),
         .dout (lane_dout_s[g])
      );
   end

   // Balanced XOR tree stored heap-style: node n combines nodes 2n+1 and
   // 2n+2, leaves start at LEAVES-1 and unused leaves are zero.
   always_comb begin
      for (int n = 0; n < 2*LEAVES-1; n++) begin
         node_s[n] = '0;
      end
      for (int j = 0; j < CHANNEL; j++) begin
         node_s[LEAVES-1+j] = lane_dout_s[j];
      end
      for (int n = LEAVES-2; n >= 0; n--) begin
         node_s[n] = node_s[2*n+1] ^ node_s[2*n+2];
      end
   end

   // S3 output register; held at zero until a real word reaches it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_r <= '0;
      end else if (vld_r[2]) begin
         out_r <= node_s[0];
      end else begin
         out_r <= '0;
      end
   end

   assign bus.out = out_r;

endmodule

// File: tb/tb_design187_70_80.sv
// tb_design187_70_80
//   Directed self-checking bench. Three instances share clk/rst:
//   CHANNEL=1, CHANNEL=2 and the 32/70 default. Inputs change on the falling
//   edge, outputs are sampled 1 time unit after the rising edge.
module tb_design187_70_80;
   import design187_70_80_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic [31:0] cap [0:511];

   design187_70_80_if #(.WIDTH(32)) bus1 ();
   design187_70_80_if #(.WIDTH(32)) bus2 ();
   design187_70_80_if #(.WIDTH(32)) busd ();

   design187_70_80 #(.WIDTH(32), .CHANNEL(1))  u_c1  (.clk(clk), .rst(rst), .bus(bus1));
   design187_70_80 #(.WIDTH(32), .CHANNEL(2))  u_c2  (.clk(clk), .rst(rst), .bus(bus2));
   design187_70_80 #(.WIDTH(32), .CHANNEL(70)) u_def (.clk(clk), .rst(rst), .bus(busd));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: XOR over lanes of s + rotl(s, i mod 32), s = x ^ K(i).
   function automatic logic [31:0] model(input int ch, input logic [31:0] x);
      logic [31:0]  acc;
      logic [31:0]  s;
      logic [31:0]  r;
      logic [127:0] kk;
      int           sh;
      acc = 32'h0;
      for (int i = 0; i < ch; i++) begin
         kk = k_of(i);
         s  = x ^ kk[31:0];
         sh = i % 32;
         if (sh == 0) r = s;
         else         r = (s << sh) | (s >> (32 - sh));
         acc = acc ^ (s + r);
      end
      return acc;
   endfunction

   // Assert rst on a falling edge and release it 10 units later (next falling edge).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #10;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      bus1.in  = 32'hABCD_EFAB;
      bus2.in  = 32'hABCD_EFAB;
      busd.in  = 32'hABCD_EFAB;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (bus1.out !== 32'h0) begin n_err++; $display("FAIL reset_c1: got %h expected %h", bus1.out, 32'h0); end
         n_cmp++;
         if (bus2.out !== 32'h0) begin n_err++; $display("FAIL reset_c2: got %h expected %h", bus2.out, 32'h0); end
         n_cmp++;
         if (busd.out !== 32'h0) begin n_err++; $display("FAIL reset_def: got %h expected %h", busd.out, 32'h0); end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_ch1();
      logic [31:0] exp_v;
      bus1.in = 32'h1234_5678;
      do_reset();
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk);
         #1;
         exp_v = (e >= 4) ? 32'h2468_ACF0 : 32'h0;
         n_cmp++;
         if (bus1.out !== exp_v) begin
            n_err++;
            $display("FAIL ch1_edge%0d: got %h expected %h", e, bus1.out, exp_v);
         end
      end
   endtask

   task automatic test_ch2();
      logic [31:0] exp_v;
      bus2.in = 32'h0;
      do_reset();
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk);
         #1;
         exp_v = (e >= 4) ? 32'hDAA6_6D2C : 32'h0;
         n_cmp++;
         if (bus2.out !== exp_v) begin
            n_err++;
            $display("FAIL ch2_edge%0d: got %h expected %h", e, bus2.out, exp_v);
         end
      end
   endtask

   task automatic test_switch();
      logic [31:0] exp_v;
      busd.in = 32'hABCD_EFAB;
      do_reset();
      for (int e = 1; e <= 12; e++) begin
         busd.in = (e <= 6) ? 32'hABCD_EFAB : 32'h1234_5678;
         cap[e]  = busd.in;
         @(posedge clk);
         #1;
         exp_v = (e >= 4) ? model(70, cap[e-3]) : 32'h0;
         n_cmp++;
         if (busd.out !== exp_v) begin
            n_err++;
            $display("FAIL switch_edge%0d: got %h expected %h", e, busd.out, exp_v);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_pulse();
      logic [31:0] exp_v;
      busd.in = 32'hAAAA_AAAA;
      do_reset();
      for (int e = 1; e <= 6; e++) begin
         @(posedge clk);
         #1;
      end
      n_cmp++;
      if (busd.out !== model(70, 32'hAAAA_AAAA)) begin
         n_err++;
         $display("FAIL pulse_pre: got %h expected %h", busd.out, model(70, 32'hAAAA_AAAA));
      end
      // Mid-cycle pulse: out must clear without waiting for a clock edge.
      #2;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (busd.out !== 32'h0) begin n_err++; $display("FAIL pulse_async: got %h expected %h", busd.out, 32'h0); end
      #9;
      n_cmp++;
      if (busd.out !== 32'h0) begin n_err++; $display("FAIL pulse_edge: got %h expected %h", busd.out, 32'h0); end
      @(negedge clk);
      rst = 1'b0;
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         exp_v = (e >= 4) ? model(70, 32'hAAAA_AAAA) : 32'h0;
         n_cmp++;
         if (busd.out !== exp_v) begin
            n_err++;
            $display("FAIL pulse_edge%0d: got %h expected %h", e, busd.out, exp_v);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_v;
      int          bad;
      busd.in = 32'h0;
      do_reset();
      bad = 0;
      for (int e = 1; e <= 400; e++) begin
         busd.in = $urandom;
         cap[e]  = busd.in;
         @(posedge clk);
         #1;
         exp_v = (e >= 4) ? model(70, cap[e-3]) : 32'h0;
         n_cmp++;
         if (busd.out !== exp_v) begin
            n_err++;
            if (bad < 10) $display("FAIL random_edge%0d: got %h expected %h", e, busd.out, exp_v);
            bad++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_ch1();
      test_ch2();
      test_switch();
      test_reset_pulse();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
